// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
// Instruction-fetch front end: issues pipelined in-order fetch requests on a
// valid/ready address channel, tags each accepted request with its PC, and
// buffers returned instructions in a prefetch FIFO that feeds Decode.
// A redirect flushes the FIFO and marks every in-flight request stale so its
// response is dropped when it eventually returns.
module fetch_prefetch_unit #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    INST_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET        = 32'h0000_0000,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_redir,
  input  logic [ADDR_WIDTH-1:0]            i_redir_pc,
  output logic [ADDR_WIDTH-1:0]            o_iaddr,
  output logic                             o_iaddr_vld,
  input  logic                             i_iaddr_rdy,
  input  logic [INST_WIDTH-1:0]            i_inst,
  input  logic                             i_inst_vld,
  input  logic                             i_stall,
  output logic                             o_if_pkt_vld,
  output logic [ADDR_WIDTH+INST_WIDTH-1:0] o_if_pkt_data
);

  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TPW-1:0] TAG_LAST = TPW'(MAX_OUTSTANDING - 1);

  // Address channel state
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_iaddr;
  logic                  r_iaddr_vld;
  logic                  r_pend_stale;   // pending address was overtaken by a redirect

  // Tag queue: one {pc, stale} entry per accepted, unanswered request
  logic [ADDR_WIDTH-1:0] r_tag_pc    [MAX_OUTSTANDING];
  logic                  r_tag_stale [MAX_OUTSTANDING];
  logic [TPW-1:0]        r_tag_rd;
  logic [TPW-1:0]        r_tag_wr;
  logic [TCW-1:0]        r_tag_cnt;

  // Prefetch FIFO
  logic [ADDR_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] r_fifo_inst [FIFO_DEPTH];
  logic [FPW-1:0]        r_fifo_rd;
  logic [FPW-1:0]        r_fifo_wr;
  logic [FPW:0]          r_fifo_cnt;

  logic                  w_accept;
  logic                  w_rsp;
  logic                  w_fifo_push;
  logic                  w_fifo_pop;
  logic                  w_chan_free;
  logic                  w_permit;
  logic [ADDR_WIDTH-1:0] w_issue_pc;
  logic [TCW-1:0]        w_tag_cnt_nxt;
  logic [FPW:0]          w_fifo_cnt_nxt;

  function automatic logic [TPW-1:0] tag_inc(input logic [TPW-1:0] p);
    return (p == TAG_LAST) ? '0 : p + TPW'(1);
  endfunction

  assign w_accept    = r_iaddr_vld & i_iaddr_rdy;
  // A response with no tag outstanding is a protocol error and is ignored.
  assign w_rsp       = i_inst_vld & (r_tag_cnt != '0);
  assign w_fifo_push = w_rsp & ~r_tag_stale[r_tag_rd] & ~i_redir;
  assign w_fifo_pop  = o_if_pkt_vld & ~i_stall;
  assign w_chan_free = ~r_iaddr_vld | w_accept;
  assign w_issue_pc  = i_redir ? i_redir_pc : r_fetch_pc;

  // Occupancy after this cycle's accept, response and pop; drives issue credit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_tag_cnt_nxt  = r_tag_cnt;
    w_fifo_cnt_nxt = r_fifo_cnt;
    if (w_accept && !w_rsp)      w_tag_cnt_nxt = r_tag_cnt + TCW'(1);
    else if (!w_accept && w_rsp) w_tag_cnt_nxt = r_tag_cnt - TCW'(1);
    if (i_redir)                          w_fifo_cnt_nxt = '0;
    else if (w_fifo_push && !w_fifo_pop)  w_fifo_cnt_nxt = r_fifo_cnt + (FPW+1)'(1);
    else if (!w_fifo_push && w_fifo_pop)  w_fifo_cnt_nxt = r_fifo_cnt - (FPW+1)'(1);
  end

  // Every issued address must have room in the FIFO when its response returns.
  assign w_permit = ((int'(w_fifo_cnt_nxt) + int'(w_tag_cnt_nxt)) < FIFO_DEPTH) &&
                    (int'(w_tag_cnt_nxt) < MAX_OUTSTANDING);

  // Address channel: hold while pending, otherwise issue next (or redirect) PC.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_fetch_pc   <= PC_RESET;
      r_iaddr      <= PC_RESET;
      r_iaddr_vld  <= 1'b0;
      r_pend_stale <= 1'b0;
    end else begin
      if (w_chan_free) begin
        r_iaddr_vld  <= w_permit;
        r_pend_stale <= 1'b0;
        if (w_permit) r_iaddr <= w_issue_pc;
      end else if (i_redir) begin
        r_pend_stale <= 1'b1;
      end
      if (w_chan_free && w_permit) r_fetch_pc <= w_issue_pc + ADDR_WIDTH'(4);
      else if (i_redir)            r_fetch_pc <= i_redir_pc;
    end
  end

  // Tag queue pointers and occupancy (outstanding count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_rd  <= '0;
      r_tag_wr  <= '0;
      r_tag_cnt <= '0;
    end else begin
      if (w_accept) r_tag_wr <= tag_inc(r_tag_wr);
      if (w_rsp)    r_tag_rd <= tag_inc(r_tag_rd);
      r_tag_cnt <= w_tag_cnt_nxt;
    end
  end

  // Tag storage: redirect poisons all entries; an accept writes a new entry.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; occupancy is tracked by the reset
    // pointers/counts, so entries are always written before they are read.
    if (i_redir) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_tag_stale[i] <= 1'b1;
    end
    if (w_accept) begin
      r_tag_pc[r_tag_wr]    <= r_iaddr;
      r_tag_stale[r_tag_wr] <= i_redir | r_pend_stale;
    end
  end

  // FIFO pointers and count; redirect flushes with priority over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
      r_fifo_cnt <= '0;
    end else if (i_redir) begin
      r_fifo_rd  <= '0;
      r_fifo_wr  <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_fifo_push) r_fifo_wr <= r_fifo_wr + FPW'(1);
      if (w_fifo_pop)  r_fifo_rd <= r_fifo_rd + FPW'(1);
      r_fifo_cnt <= w_fifo_cnt_nxt;
    end
  end

  // FIFO storage: capture {tag pc, instruction} for live responses.
  always_ff @(posedge clk) begin
    if (w_fifo_push) begin
      r_fifo_pc[r_fifo_wr]   <= r_tag_pc[r_tag_rd];
      r_fifo_inst[r_fifo_wr] <= i_inst;
    end
  end

  assign o_iaddr       = r_iaddr;
  assign o_iaddr_vld   = r_iaddr_vld;
  assign o_if_pkt_vld  = (r_fifo_cnt != '0);
  assign o_if_pkt_data = o_if_pkt_vld ? {r_fifo_pc[r_fifo_rd], r_fifo_inst[r_fifo_rd]} : '0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Testbench for fetch_prefetch_unit: in-order memory model, packet scoreboard,
// vector tables for steady flow / back-pressure, and hand-written redirect,
// credit, wrap and reset sequences.
module tb_fetch_prefetch_unit;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam logic [AW-1:0] PC_RST = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_redir = 1'b0;
  logic [AW-1:0] i_redir_pc = '0;
  logic [AW-1:0] o_iaddr;
  logic          o_iaddr_vld;
  logic          i_iaddr_rdy = 1'b0;
  logic [IW-1:0] i_inst = '0;
  logic          i_inst_vld = 1'b0;
  logic          i_stall = 1'b0;
  logic          o_if_pkt_vld;
  logic [AW+IW-1:0] o_if_pkt_data;

  fetch_prefetch_unit #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .PC_RESET(PC_RST),
    .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_redir(i_redir), .i_redir_pc(i_redir_pc),
    .o_iaddr(o_iaddr), .o_iaddr_vld(o_iaddr_vld), .i_iaddr_rdy(i_iaddr_rdy),
    .i_inst(i_inst), .i_inst_vld(i_inst_vld), .i_stall(i_stall),
    .o_if_pkt_vld(o_if_pkt_vld), .o_if_pkt_data(o_if_pkt_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy;
    logic          stall;
    logic          exp_vld;
    logic [AW-1:0] exp_addr;
    logic          exp_pkt;
  } vec_t;

  vec_t          vecs[$];
  logic [AW-1:0] mem_q[$];   // accepted addresses awaiting a response
  logic [AW-1:0] exp_q[$];   // PCs expected on the packet output, in order
  logic [AW-1:0] pop_log[$]; // PCs of packets consumed
  logic          skip;       // after a redirect, ignore accepts until its target
  logic [AW-1:0] skip_pc;

  logic          cfg_rdy, cfg_stall, cfg_hold, cfg_redir, cfg_spur;
  logic [AW-1:0] cfg_redir_pc;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
    return (pc * 32'd3) ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: consume packet, model memory, drive inputs, advance one cycle.
  task automatic drive_cycle();
    logic [AW-1:0] a;
    if (o_if_pkt_vld && !cfg_stall) begin
      check("pkt_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        a = exp_q.pop_front();
        check("pkt_data", 64'(o_if_pkt_data), {a, inst_of(a)});
      end
      pop_log.push_back(o_if_pkt_data[AW+IW-1:IW]);
    end
    if (cfg_redir) begin
      exp_q.delete();
      skip    = 1'b1;
      skip_pc = cfg_redir_pc;
    end
    if (cfg_spur) begin
      i_inst_vld = 1'b1;
      i_inst     = 32'hBAD0_0BAD;
    end else if (!cfg_hold && mem_q.size() != 0) begin
      a          = mem_q.pop_front();
      i_inst_vld = 1'b1;
      i_inst     = inst_of(a);
    end else begin
      i_inst_vld = 1'b0;
      i_inst     = $urandom;
    end
    if (o_iaddr_vld && cfg_rdy) begin
      mem_q.push_back(o_iaddr);
      if (!skip || o_iaddr == skip_pc) begin
        skip = 1'b0;
        exp_q.push_back(o_iaddr);
      end
    end
    i_iaddr_rdy = cfg_rdy;
    i_stall     = cfg_stall;
    i_redir     = cfg_redir;
    i_redir_pc  = cfg_redir ? cfg_redir_pc : $urandom;
    cfg_redir   = 1'b0;
    cfg_spur    = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge: assert reset, check reset outputs, release; returns in cycle 0.
  task automatic do_reset();
    rst_n       = 1'b0;
    i_redir     = 1'b0;
    i_iaddr_rdy = 1'b0;
    i_inst_vld  = 1'b0;
    i_stall     = 1'b0;
    cfg_rdy = 1'b1; cfg_stall = 1'b0; cfg_hold = 1'b0; cfg_redir = 1'b0; cfg_spur = 1'b0;
    cfg_redir_pc = '0;
    #1;
    check("rst iaddr_vld", 64'(o_iaddr_vld), 64'd0);
    check("rst iaddr", 64'(o_iaddr), 64'(PC_RST));
    check("rst pkt_vld", 64'(o_if_pkt_vld), 64'd0);
    check("rst pkt_data", 64'(o_if_pkt_data), 64'd0);
    mem_q.delete(); exp_q.delete(); pop_log.delete();
    skip = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vectors(input string tag);
    foreach (vecs[i]) begin
      check($sformatf("%s[%0d] iaddr_vld", tag, i), 64'(o_iaddr_vld), 64'(vecs[i].exp_vld));
      check($sformatf("%s[%0d] iaddr", tag, i), 64'(o_iaddr), 64'(vecs[i].exp_addr));
      check($sformatf("%s[%0d] pkt_vld", tag, i), 64'(o_if_pkt_vld), 64'(vecs[i].exp_pkt));
      cfg_rdy   = vecs[i].rdy;
      cfg_stall = vecs[i].stall;
      drive_cycle();
    end
  endtask

  task automatic wait_addr(input logic [AW-1:0] target, input string tag);
    int k = 0;
    while (!(o_iaddr_vld && o_iaddr == target) && k < 50) begin
      drive_cycle();
      k++;
    end
    check({tag, " addr_reached"}, 64'(o_iaddr_vld && o_iaddr == target), 64'd1);
  endtask

  task automatic wait_pops(input int n, input string tag);
    int k = 0;
    while (pop_log.size() < n && k < 40) begin
      drive_cycle();
      k++;
    end
    check({tag, " pops_in_time"}, 64'(pop_log.size() >= n), 64'd1);
  endtask

  task automatic check_pops(input string tag, input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    wait_pops(2, tag);
    if (pop_log.size() >= 2) begin
      check({tag, " first_pc"}, 64'(pop_log[0]), 64'(p0));
      check({tag, " second_pc"}, 64'(pop_log[1]), 64'(p1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // Steady flow: one request and one packet per cycle.
    do_reset();
    vecs.delete();
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h04, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h08, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h10, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h14, 1'b1});
    run_vectors("flow");

    // Address back-pressure: 0x8 held for three cycles, accepted on the fourth.
    do_reset();
    vecs.delete();
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h04, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h08, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h08, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h08, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h08, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h0C, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h10, 1'b1});
    run_vectors("hold");

    // Decode stall: FIFO fills to depth, issue stops, nothing lost on release.
    do_reset();
    cfg_stall = 1'b1;
    for (int i = 0; i < 12; i++) drive_cycle();
    check("stall iaddr_vld_dropped", 64'(o_iaddr_vld), 64'd0);
    check("stall fifo_vld", 64'(o_if_pkt_vld), 64'd1);
    cfg_spur = 1'b1;   // response with no outstanding request
    drive_cycle();
    cfg_stall = 1'b0;
    pop_log.delete();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain[%0d] pkt_vld", i), 64'(o_if_pkt_vld), 64'd1);
      drive_cycle();
    end
    check("drain count", 64'(pop_log.size()), 64'd4);
    if (pop_log.size() == 4) begin
      check("drain pc0", 64'(pop_log[0]), 64'h0);
      check("drain pc3", 64'(pop_log[3]), 64'hC);
    end
    cfg_rdy = 1'b0;
    for (int i = 0; i < 10; i++) drive_cycle();
    check("drain scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Redirect with two requests outstanding: late responses dropped.
    do_reset();
    wait_addr(32'h10, "redir_out");
    drive_cycle();
    cfg_hold = 1'b1; cfg_stall = 1'b1;
    check("redir_out second_addr", 64'(o_iaddr), 64'h14);
    drive_cycle();
    check("redir_out credit_stop", 64'(o_iaddr_vld), 64'd0);
    check("redir_out pkt_before", 64'(o_if_pkt_vld), 64'd1);
    cfg_redir = 1'b1; cfg_redir_pc = 32'h100;
    drive_cycle();
    check("redir_out pkt_flushed", 64'(o_if_pkt_vld), 64'd0);
    cfg_hold = 1'b0; cfg_stall = 1'b0;
    pop_log.delete();
    check_pops("redir_out", 32'h100, 32'h104);

    // Redirect while 0x20 is pending and unaccepted.
    do_reset();
    wait_addr(32'h20, "redir_pend");
    cfg_rdy = 1'b0; cfg_redir = 1'b1; cfg_redir_pc = 32'h200;
    drive_cycle();
    check("redir_pend held1", 64'({o_iaddr_vld, o_iaddr}), 64'h1_0000_0020);
    drive_cycle();
    check("redir_pend held2", 64'({o_iaddr_vld, o_iaddr}), 64'h1_0000_0020);
    cfg_rdy = 1'b1;
    pop_log.delete();
    drive_cycle();
    check("redir_pend next_addr", 64'({o_iaddr_vld, o_iaddr}), 64'h1_0000_0200);
    check_pops("redir_pend", 32'h200, 32'h204);

    // PC wrap at the top of the address space.
    do_reset();
    pop_log.delete();
    cfg_redir = 1'b1; cfg_redir_pc = 32'hFFFF_FFFC;
    drive_cycle();
    check("wrap addr_top", 64'(o_iaddr), 64'hFFFF_FFFC);
    drive_cycle();
    check("wrap addr_zero", 64'({o_iaddr_vld, o_iaddr}), 64'h1_0000_0000);
    check_pops("wrap", 32'hFFFF_FFFC, 32'h0);

    // Reset mid-burst: outputs clear immediately, restart at PC_RESET.
    for (int i = 0; i < 3; i++) drive_cycle();
    check("midrst pkt_vld_before", 64'(o_if_pkt_vld), 64'd1);
    do_reset();
    check("midrst restart", 64'({o_iaddr_vld, o_iaddr}), {31'd0, 1'b1, PC_RST});
    check("midrst pkt_vld_after", 64'(o_if_pkt_vld), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
